// File: rtl/norm_pipe.sv
// Two-stage FP normalize/round pipeline with valid/ready on both sides.
// Define NORM_ROUND_EN for round-to-nearest-even; otherwise the fraction is truncated.
module norm_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int GRD_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sign,
    input  logic [EXP_W-1:0]       in_exp,
    input  logic [MAN_W+GRD_W+1:0] in_mant,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out_result,
    output logic                   out_of,
    output logic                   out_uf,
    output logic                   out_inexact
);

    localparam int MW  = MAN_W + 2 + GRD_W;
    localparam int EW  = EXP_W + 2;
    localparam int RW  = 1 + EXP_W + MAN_W;
    localparam int LZW = $clog2(MW);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);

    function automatic logic [LZW-1:0] lead_zeros(input logic [MW-2:0] v);
        logic [LZW-1:0] n;
        logic           found;
        n     = '0;
        found = 1'b0;
        for (int i = MW - 2; i >= 0; i--) begin
            if (v[i]) found = 1'b1;
            else if (!found) n = n + LZW'(1);
        end
        return n;
    endfunction

`ifdef NORM_ROUND_EN
    function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] frac,
                                                 input logic guard,
                                                 input logic sticky);
        return {1'b0, frac} + {{MAN_W{1'b0}}, guard & (sticky | frac[0])};
    endfunction
`endif

    // Returns {result, of, uf, inexact}; saturates to infinity or flushes to zero.
    function automatic logic [RW+2:0] sat_pack(input logic sign,
                                               input logic signed [EW-1:0] expo,
                                               input logic [MAN_W-1:0] frac,
                                               input logic zero,
                                               input logic inexact);
        if (zero)
            return {sign, {(RW+2){1'b0}}};
        if (expo >= EXP_MAX)
            return {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}, 3'b101};
        if (expo <= EXP_ZERO)
            return {sign, {(EXP_W+MAN_W){1'b0}}, 3'b011};
        return {sign, expo[EXP_W-1:0], frac, 2'b00, inexact};
    endfunction

    logic s1_en, s2_en;
    logic vld_p1, vld_p2;

    assign s2_en    = !vld_p2 || out_ready;
    assign s1_en    = !vld_p1 || s2_en;
    assign in_ready = s1_en;

    // Stage 1: normalize so the hidden one lands at bit MW-2
    logic [LZW-1:0]       lz_s1;
    logic signed [EW-1:0] exp_in_s1, exp_s1;
    logic [MW-2:0]        mant_s1;
    logic                 sticky_s1;

    always_comb begin
        exp_in_s1 = signed'({2'b00, in_exp});
        lz_s1     = lead_zeros(in_mant[MW-2:0]);
        mant_s1   = in_mant[MW-2:0];
        exp_s1    = exp_in_s1;
        sticky_s1 = 1'b0;
        if (in_mant[MW-1]) begin
            mant_s1   = in_mant[MW-1:1];
            sticky_s1 = in_mant[0];
            exp_s1    = exp_in_s1 + EXP_ONE;
        end else if (!in_mant[MW-2]) begin
            mant_s1 = in_mant[MW-2:0] << lz_s1;
            exp_s1  = exp_in_s1 - signed'(EW'(lz_s1));
        end
    end

    logic                 sign_p1, sticky_p1;
    logic signed [EW-1:0] exp_p1;
    logic [MW-2:0]        mant_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p1 <= 1'b0;
        else if (s1_en) vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (s1_en && in_valid) begin
            sign_p1   <= in_sign;
            exp_p1    <= exp_s1;
            mant_p1   <= mant_s1;
            sticky_p1 <= sticky_s1;
        end
    end

    // Stage 2: round, then range-check and pack; a cleared hidden bit means a zero input
    logic [MAN_W-1:0]     frac_s2;
    logic                 guard_s2, sticky_s2;
    logic [MAN_W:0]       rnd_s2;
    logic signed [EW-1:0] exp_s2;
    logic [RW+2:0]        pack_s2;

    always_comb begin
        frac_s2   = mant_p1[MW-3:GRD_W];
        guard_s2  = mant_p1[GRD_W-1];
        sticky_s2 = sticky_p1 | (|mant_p1[GRD_W-2:0]);
`ifdef NORM_ROUND_EN
        rnd_s2    = round_rne(frac_s2, guard_s2, sticky_s2);
`else
        rnd_s2    = {1'b0, frac_s2};
`endif
        exp_s2    = rnd_s2[MAN_W] ? exp_p1 + EXP_ONE : exp_p1;
        pack_s2   = sat_pack(sign_p1, exp_s2, rnd_s2[MAN_W-1:0], !mant_p1[MW-2],
                             guard_s2 | sticky_s2);
    end

    logic [RW-1:0] res_p2;
    logic          of_p2, uf_p2, inx_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            res_p2 <= '0;
            of_p2  <= 1'b0;
            uf_p2  <= 1'b0;
            inx_p2 <= 1'b0;
        end else if (s2_en) begin
            vld_p2 <= vld_p1;
            if (vld_p1) {res_p2, of_p2, uf_p2, inx_p2} <= pack_s2;
        end
    end

    assign out_valid   = vld_p2;
    assign out_result  = res_p2;
    assign out_of      = of_p2;
    assign out_uf      = uf_p2;
    assign out_inexact = inx_p2;

endmodule

// File: tb/tb_norm_pipe.sv
// Bench for norm_pipe: directed FP16 vectors, back-pressure, reset, and random traffic
// scored against a value-level model (msb position, round, range check).
module tb_norm_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int GRD_W = 8;
    localparam int MW    = MAN_W + 2 + GRD_W;
    localparam int RW    = 1 + EXP_W + MAN_W;

    typedef struct packed {
        logic [RW-1:0] res;
        logic          of;
        logic          uf;
        logic          inx;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_sign;
    logic [EXP_W-1:0]  in_exp;
    logic [MW-1:0]     in_mant;
    logic              out_valid, out_ready;
    logic [RW-1:0]     out_result;
    logic              out_of, out_uf, out_inexact;

    always #5 clk = ~clk;

    norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .GRD_W(GRD_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_of(out_of), .out_uf(out_uf),
        .out_inexact(out_inexact)
    );

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    bit   hold_v;
    exp_t held;

    function automatic exp_t mk(logic [RW-1:0] res, bit of, bit uf, bit inx);
        exp_t r;
        r.res = res; r.of = of; r.uf = uf; r.inx = inx;
        return r;
    endfunction

    // Value-level reference: find the msb, keep MAN_W bits below it, round, range-check.
    function automatic exp_t model(bit s, int e, longint unsigned m);
        exp_t            r;
        int              p, ee, sh;
        longint unsigned kept;
        bit              g, st;
        r = '0;
        if (m == 0) begin
            r.res = {s, {(RW-1){1'b0}}};
            return r;
        end
        p = 0;
        for (int i = 0; i < MW; i++) if (m[i]) p = i;
        ee = e + p - (MW - 2);
        sh = p - MAN_W;
        g = 1'b0; st = 1'b0;
        if (sh > 0) begin
            kept = m >> sh;
            g    = m[sh-1];
            st   = (m & ((64'd1 << (sh - 1)) - 64'd1)) != 0;
        end else begin
            kept = m << (-sh);
        end
`ifdef NORM_ROUND_EN
        if (g && (st || kept[0])) kept++;
        if ((kept >> (MAN_W + 1)) != 0) begin
            kept = kept >> 1;
            ee++;
        end
`endif
        r.inx = g | st;
        if (ee >= (1 << EXP_W) - 1) begin
            r.res = {s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            r.of = 1'b1; r.inx = 1'b1;
        end else if (ee <= 0) begin
            r.res = {s, {(RW-1){1'b0}}};
            r.uf = 1'b1; r.inx = 1'b1;
        end else begin
            r.res = {s, ee[EXP_W-1:0], kept[MAN_W-1:0]};
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: sample at negedge+1, score outputs, record acceptance, advance to next negedge.
    task automatic cycle(input exp_t nx, output bit acc);
        exp_t e;
        #1;
        check("in_ready", {31'd0, in_ready}, (sbq.size() == 2 && !out_ready) ? 32'd0 : 32'd1);
        if (hold_v) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {13'd0, out_result, out_of, out_uf, out_inexact}, {13'd0, held});
        end
        hold_v = out_valid && !out_ready;
        held   = {out_result, out_of, out_uf, out_inexact};
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                check("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("result", {16'd0, out_result}, {16'd0, e.res});
                check("flags", {29'd0, out_of, out_uf, out_inexact}, {29'd0, e.of, e.uf, e.inx});
            end
        end
        acc = in_valid && in_ready;
        if (acc) sbq.push_back(nx);
        @(negedge clk);
    endtask

    task automatic send_one(input bit s, input int e, input int m, input exp_t x);
        bit acc;
        int n;
        in_valid = 1'b1; in_sign = s; in_exp = e[EXP_W-1:0]; in_mant = m[MW-1:0];
        out_ready = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 10) begin
            cycle(x, acc);
            n++;
        end
        in_valid = 1'b0;
        check("accept", {31'd0, acc}, 32'd1);
        #1 check("lat1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1 check("lat2", {31'd0, out_valid}, 32'd1);
        cycle(x, acc);
    endtask

    task automatic gen_beat(output bit s, output int e, output logic [MW-1:0] m);
        case ($urandom_range(0, 4))
            0: m = {1'b1, (MW-1)'($urandom)};
            1: m = {2'b01, (MW-2)'($urandom)};
            2: m = MW'({2'b00, (MW-2)'($urandom)} >> $urandom_range(1, MW - 2));
            3: m = '0;
            default: m = MW'($urandom);
        endcase
        e = $urandom_range(0, (1 << EXP_W) - 1);
        s = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit              acc, rs;
        int              re, sent;
        logic [MW-1:0]   rm;
        bit              bs[6];
        int              be[6];
        logic [MW-1:0]   bm[6];

        rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
        out_ready = 1'b0; hold_v = 1'b0; held = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", {16'd0, out_result}, 32'd0);
        check("rst_flags", {29'd0, out_of, out_uf, out_inexact}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        send_one(1'b0, 15, 'h80000, mk(16'h4000, 0, 0, 0));
        send_one(1'b0, 15, 'h10000, mk(16'h3400, 0, 0, 0));
        send_one(1'b0, 15, 'h00000, mk(16'h0000, 0, 0, 0));
        send_one(1'b1, 9,  'h00000, mk(16'h8000, 0, 0, 0));
        send_one(1'b0, 15, 'h40080, mk(16'h3C00, 0, 0, 1));
`ifdef NORM_ROUND_EN
        send_one(1'b0, 15, 'h40180, mk(16'h3C02, 0, 0, 1));
`else
        send_one(1'b0, 15, 'h40180, mk(16'h3C01, 0, 0, 1));
`endif
        send_one(1'b0, 30, 'h80000, mk(16'h7C00, 1, 0, 1));
        send_one(1'b0, 2,  'h08000, mk(16'h0000, 0, 1, 1));

        for (int i = 0; i < 6; i++) begin
            gen_beat(rs, re, rm);
            bs[i] = rs; be[i] = re; bm[i] = rm;
        end
        sent = 0;
        for (int c = 0; c < 40 && (sent < 6 || sbq.size() > 0); c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                in_sign = bs[sent]; in_exp = be[sent][EXP_W-1:0]; in_mant = bm[sent];
                cycle(model(bs[sent], be[sent], bm[sent]), acc);
            end else begin
                cycle('0, acc);
            end
            if (acc) sent++;
        end
        in_valid = 1'b0;
        check("bp_sent", sent, 6);
        check("bp_drained", sbq.size(), 0);

        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            gen_beat(rs, re, rm);
            in_sign = rs; in_exp = re[EXP_W-1:0]; in_mant = rm;
            cycle(model(rs, re, rm), acc);
        end
        in_valid = 1'b0;
        #1 check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_result", {16'd0, out_result}, 32'd0);
        check("mid_rst_flags", {29'd0, out_of, out_uf, out_inexact}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sbq.delete();
        hold_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("post_rst_idle", {31'd0, out_valid}, 32'd0);
            @(negedge clk);
        end
        send_one(1'b1, 20, 'h40000, mk(16'hD000, 0, 0, 0));

        gen_beat(rs, re, rm);
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_sign = rs; in_exp = re[EXP_W-1:0]; in_mant = rm;
            cycle(model(rs, re, rm), acc);
            if (acc) gen_beat(rs, re, rm);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10 && sbq.size() > 0; i++) cycle('0, acc);
        check("final_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/norm_pipe.md
# norm_pipe

Parametrised two-stage floating-point normalize/round pipeline for the MAC datapath. Takes the raw sign/exponent/extended mantissa from the add stage and fully normalizes it:
- right shift on carry-out;
- left shift by leading-zero count on cancellation.

It then rounds, detects overflow/underflow and packs an IEEE-style result. Valid/ready handshakes on both sides allow back-pressure. This generalises the FP16 single-step normalizer to any exponent/mantissa width.

## Interface
Parameters:
- EXP_W, 5, exponent field width
- MAN_W, 10, stored fraction width
- GRD_W, 8, guard/extra bits below the fraction LSB (≥2)
- MW (derived, not overridable) = MAN_W+2+GRD_W, input mantissa width

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input this cycle
- in_sign  in  1  sign
- in_exp  in  EXP_W  biased exponent, unsigned
- in_mant  in  MW  mantissa: bits [MW-1:MW-2] integer, binary point below bit MW-2
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  1+EXP_W+MAN_W  {sign, exp, frac}
- out_of  out  1  overflow, result saturated to infinity
- out_uf  out  1  underflow, result flushed to zero
- out_inexact  out  1  discarded bits nonzero

## Operation
- Stage 1 (shift): exponent arithmetic is signed, EXP_W+2 bits.
  - in_mant[MW-1]=1: shift right 1, exp+1. The shifted-out bit ORs into sticky.
  - in_mant[MW-1:MW-2]=01: no shift.
  - Otherwise: lz = leading zeros of in_mant[MW-3:0] plus 1; shift left lz, exp−lz.
  - in_mant==0: zero result, sign kept, exp 0, no flags.
- Stage 2 (round/pack):
  - Kept fraction = bits below the hidden 1, MAN_W wide. Guard = next bit. Sticky = OR of all remaining bits.
  - Rounding per Configuration. A carry out of the hidden bit sets frac=0 and exp+1.
  - Final exp ≥ 2^EXP_W−1: result {sign, all-ones, 0}, out_of=1, out_inexact=1.
  - Final exp ≤ 0 with nonzero mantissa: result {sign, 0, 0}, out_uf=1, out_inexact=1. No subnormals are produced.
  - out_inexact = guard|sticky otherwise.
- Handshake:
  - s2_en = !s2_valid | out_ready
  - s1_en = !s1_valid | s2_en
  - in_ready = s1_en; this is combinational from out_ready.
  - Transfer occurs when valid&ready. Stalled stages hold data unchanged.
  - A stage with valid=0 may load freely.

## Timing
- Latency: 2 cycles from input accept to out_valid, with out_ready held 1.
- Throughput: 1 result/cycle with no stall.
- Capacity: 2 in-flight results. With out_ready=0, in_ready falls after both stages fill.
- out_* data is stable while out_valid=1 and out_ready=0.
- Reset (async assert, sync-to-clk release): s1/s2 valid=0, in_ready=1, out_valid=0, out_result=0, out_of=out_uf=out_inexact=0. Reset mid-stream drops in-flight beats.
- Simultaneous drain and fill of a full pipeline in the same cycle is legal and loses nothing.

## Configuration
- NORM_ROUND_EN defined: round-to-nearest-even.
  - Increment when guard & (sticky | frac LSB).
  - The overflow check is applied after the rounding carry.
- NORM_ROUND_EN undefined: truncate, no rounding incrementer.
  - out_inexact is still reported.
  - Overflow only from the stage-1 exponent increment.

## Test plan
Defaults are FP16: EXP_W=5, MAN_W=10, GRD_W=8, MW=20.
- Carry-out: sign 0, exp 15, mant 20'h80000 (2.0) -> 0x4000 after 2 cycles, no flags.
- Cancellation: exp 15, mant 20'h10000 (0.25) -> 0x3400; mant 0 -> 0x0000, no flags.
- Rounding (NORM_ROUND_EN):
  - exp 15, mant 20'h40080 (tie, LSB 0) -> 0x3C00, inexact=1.
  - mant 20'h40180 (tie, LSB 1) -> 0x3C02.
  - Without the macro: 0x3C00 and 0x3C01 respectively.
- Overflow/underflow:
  - exp 30, mant 20'h80000 -> 0x7C00, out_of=1.
  - exp 2, mant 20'h08000 -> 0x0000, out_uf=1.
- Back-pressure: 6 back-to-back beats, out_ready low cycles 3–6 -> in_ready low while full. All 6 results emerge in order, no duplicates or drops.
- Reset: assert rst_n=0 with 2 beats in flight -> outputs 0 immediately, out_valid stays 0 after release until a new input.
